// File: rtl/axi_noc_pkg.sv
// rtl/axi_noc_pkg.sv - shared AXI encodings, arbiter state type and slave ID width helper
package axi_noc_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  // OPEN: grant follows the current requests; HELD: a presented request waits for ready
  typedef enum logic {
    ARB_OPEN = 1'b0,
    ARB_HELD = 1'b1
  } arb_state_e;

  // Slave-side IDs carry one extra top bit naming the originating master
  function automatic int slave_idw(input int idw);
    return idw + 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter whose grant is held until handshake
module rr_arb2
  import axi_noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic       gnt_o
);

  arb_state_e state_q;
  logic       rr_q;
  logic       held_q;

  // Grant: the held master while a presented request is pending, else round-robin pick
  always_comb begin
    gnt_o = 1'b0;
    if (state_q == ARB_HELD) begin
      gnt_o = held_q;
    end else if (req_i == 2'b11) begin
      gnt_o = rr_q;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end
  end

  assign valid_o = en_i && req_i[gnt_o];

  // Lock on a stalled request, release and rotate priority on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_OPEN;
      rr_q    <= 1'b0;
      held_q  <= 1'b0;
    end else if (valid_o && ready_i) begin
      state_q <= ARB_OPEN;
      rr_q    <= ~gnt_o;
    end else if (valid_o) begin
      state_q <= ARB_HELD;
      held_q  <= gnt_o;
    end
  end

endmodule

// File: rtl/syncfifo_sampled.sv
// rtl/syncfifo_sampled.sv - small synchronous FIFO with registered storage and occupancy count
module syncfifo_sampled #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the same cycle, so a full FIFO may still take a push
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers and occupancy
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = nxt(wptr_q);
    if (do_pop)  rptr_d = nxt(rptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only read while the count says valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_ram_arb2.sv
// rtl/axi_ram_arb2.sv - two-master to one-slave AXI4 arbiter in front of a shared RAM slave
module axi_ram_arb2
  import axi_noc_pkg::*;
#(
  parameter int AWID   = 32,
  parameter int IDWID  = 4,
  parameter int DWID   = 64,
  parameter int WSTRB  = DWID / 8,
  parameter int WDEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // master 0
  input  logic [IDWID-1:0]              m0_arid,
  input  logic [AWID-1:0]               m0_araddr,
  input  logic [7:0]                    m0_arlen,
  input  logic [2:0]                    m0_arsize,
  input  logic [1:0]                    m0_arburst,
  input  logic                          m0_arvalid,
  output logic                          m0_arready,
  output logic [IDWID-1:0]              m0_rid,
  output logic [DWID-1:0]               m0_rdata,
  output logic [1:0]                    m0_rresp,
  output logic                          m0_rlast,
  output logic                          m0_rvalid,
  input  logic                          m0_rready,
  input  logic [IDWID-1:0]              m0_awid,
  input  logic [AWID-1:0]               m0_awaddr,
  input  logic [7:0]                    m0_awlen,
  input  logic [2:0]                    m0_awsize,
  input  logic [1:0]                    m0_awburst,
  input  logic                          m0_awvalid,
  output logic                          m0_awready,
  input  logic [DWID-1:0]               m0_wdata,
  input  logic [WSTRB-1:0]              m0_wstrb,
  input  logic                          m0_wlast,
  input  logic                          m0_wvalid,
  output logic                          m0_wready,
  output logic [IDWID-1:0]              m0_bid,
  output logic [1:0]                    m0_bresp,
  output logic                          m0_bvalid,
  input  logic                          m0_bready,
  // master 1
  input  logic [IDWID-1:0]              m1_arid,
  input  logic [AWID-1:0]               m1_araddr,
  input  logic [7:0]                    m1_arlen,
  input  logic [2:0]                    m1_arsize,
  input  logic [1:0]                    m1_arburst,
  input  logic                          m1_arvalid,
  output logic                          m1_arready,
  output logic [IDWID-1:0]              m1_rid,
  output logic [DWID-1:0]               m1_rdata,
  output logic [1:0]                    m1_rresp,
  output logic                          m1_rlast,
  output logic                          m1_rvalid,
  input  logic                          m1_rready,
  input  logic [IDWID-1:0]              m1_awid,
  input  logic [AWID-1:0]               m1_awaddr,
  input  logic [7:0]                    m1_awlen,
  input  logic [2:0]                    m1_awsize,
  input  logic [1:0]                    m1_awburst,
  input  logic                          m1_awvalid,
  output logic                          m1_awready,
  input  logic [DWID-1:0]               m1_wdata,
  input  logic [WSTRB-1:0]              m1_wstrb,
  input  logic                          m1_wlast,
  input  logic                          m1_wvalid,
  output logic                          m1_wready,
  output logic [IDWID-1:0]              m1_bid,
  output logic [1:0]                    m1_bresp,
  output logic                          m1_bvalid,
  input  logic                          m1_bready,
  // slave
  output logic [slave_idw(IDWID)-1:0]   s_arid,
  output logic [AWID-1:0]               s_araddr,
  output logic [7:0]                    s_arlen,
  output logic [2:0]                    s_arsize,
  output logic [1:0]                    s_arburst,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [slave_idw(IDWID)-1:0]   s_rid,
  input  logic [DWID-1:0]               s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rlast,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [slave_idw(IDWID)-1:0]   s_awid,
  output logic [AWID-1:0]               s_awaddr,
  output logic [7:0]                    s_awlen,
  output logic [2:0]                    s_awsize,
  output logic [1:0]                    s_awburst,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [DWID-1:0]               s_wdata,
  output logic [WSTRB-1:0]              s_wstrb,
  output logic                          s_wlast,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  input  logic [slave_idw(IDWID)-1:0]   s_bid,
  input  logic [1:0]                    s_bresp,
  input  logic                          s_bvalid,
  output logic                          s_bready
);

  logic ar_valid, ar_gnt;
  logic aw_valid, aw_gnt;
  logic wq_full, wq_empty, wq_push, wq_pop;
  logic [0:0] wq_head;
  logic w_live, w_sel;
  logic r_sel, b_sel;

  // ---------------- read address ----------------
  rr_arb2 u_ar_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   ({m1_arvalid, m0_arvalid}),
    .en_i    (rst_n),
    .ready_i (s_arready),
    .valid_o (ar_valid),
    .gnt_o   (ar_gnt)
  );

  assign s_arvalid  = ar_valid;
  assign s_arid     = {ar_gnt, (ar_gnt ? m1_arid : m0_arid)};
  assign s_araddr   = ar_gnt ? m1_araddr  : m0_araddr;
  assign s_arlen    = ar_gnt ? m1_arlen   : m0_arlen;
  assign s_arsize   = ar_gnt ? m1_arsize  : m0_arsize;
  assign s_arburst  = ar_gnt ? m1_arburst : m0_arburst;
  assign m0_arready = ar_valid && s_arready && !ar_gnt;
  assign m1_arready = ar_valid && s_arready &&  ar_gnt;

  // ---------------- write address ----------------
  // No AW is offered while the W-order FIFO cannot record its owner
  rr_arb2 u_aw_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   ({m1_awvalid, m0_awvalid}),
    .en_i    (rst_n && !wq_full),
    .ready_i (s_awready),
    .valid_o (aw_valid),
    .gnt_o   (aw_gnt)
  );

  assign s_awvalid  = aw_valid;
  assign s_awid     = {aw_gnt, (aw_gnt ? m1_awid : m0_awid)};
  assign s_awaddr   = aw_gnt ? m1_awaddr  : m0_awaddr;
  assign s_awlen    = aw_gnt ? m1_awlen   : m0_awlen;
  assign s_awsize   = aw_gnt ? m1_awsize  : m0_awsize;
  assign s_awburst  = aw_gnt ? m1_awburst : m0_awburst;
  assign m0_awready = aw_valid && s_awready && !aw_gnt;
  assign m1_awready = aw_valid && s_awready &&  aw_gnt;

  // ---------------- write data ordering ----------------
  assign wq_push = aw_valid && s_awready;
  assign wq_pop  = s_wvalid && s_wready && s_wlast;

  syncfifo_sampled #(
    .WIDTH (1),
    .DEPTH (WDEPTH)
  ) u_wq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wq_push),
    .wdata_i (aw_gnt),
    .pop_i   (wq_pop),
    .rdata_o (wq_head),
    .full_o  (wq_full),
    .empty_o (wq_empty)
  );

  // W beats flow only from the master owning the oldest unfinished write burst
  assign w_live    = rst_n && !wq_empty;
  assign w_sel     = wq_head[0];
  assign s_wvalid  = w_live && (w_sel ? m1_wvalid : m0_wvalid);
  assign s_wdata   = w_sel ? m1_wdata : m0_wdata;
  assign s_wstrb   = w_sel ? m1_wstrb : m0_wstrb;
  assign s_wlast   = w_sel ? m1_wlast : m0_wlast;
  assign m0_wready = w_live && !w_sel && s_wready;
  assign m1_wready = w_live &&  w_sel && s_wready;

  // ---------------- read response ----------------
  assign r_sel     = s_rid[IDWID];
  assign m0_rvalid = rst_n && s_rvalid && !r_sel;
  assign m1_rvalid = rst_n && s_rvalid &&  r_sel;
  assign m0_rid    = s_rid[IDWID-1:0];
  assign m1_rid    = s_rid[IDWID-1:0];
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m1_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m1_rlast  = s_rlast;
  assign s_rready  = rst_n && (r_sel ? m1_rready : m0_rready);

  // ---------------- write response ----------------
  assign b_sel     = s_bid[IDWID];
  assign m0_bvalid = rst_n && s_bvalid && !b_sel;
  assign m1_bvalid = rst_n && s_bvalid &&  b_sel;
  assign m0_bid    = s_bid[IDWID-1:0];
  assign m1_bid    = s_bid[IDWID-1:0];
  assign m0_bresp  = s_bresp;
  assign m1_bresp  = s_bresp;
  assign s_bready  = rst_n && (b_sel ? m1_bready : m0_bready);

endmodule

// File: tb/tb_axi_ram_arb2.sv
// tb/tb_axi_ram_arb2.sv - self-checking bench for axi_ram_arb2
module tb_axi_ram_arb2;
  import axi_noc_pkg::*;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int WD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [IW-1:0] arid [2], awid [2], rid [2], bid [2];
  logic [AW-1:0] araddr [2], awaddr [2];
  logic [7:0]    arlen [2], awlen [2];
  logic [2:0]    arsize [2], awsize [2];
  logic [1:0]    arburst [2], awburst [2], rresp [2], bresp [2];
  logic          arvalid [2], arready [2], rlast [2], rvalid [2], rready [2];
  logic          awvalid [2], awready [2], wlast [2], wvalid [2], wready [2];
  logic          bvalid [2], bready [2];
  logic [DW-1:0] wdata [2], rdata [2];
  logic [SW-1:0] wstrb [2];

  logic [IW:0]   s_arid, s_rid, s_awid, s_bid;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [7:0]    s_arlen, s_awlen;
  logic [2:0]    s_arsize, s_awsize;
  logic [1:0]    s_arburst, s_awburst, s_rresp, s_bresp;
  logic          s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic          s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic          s_bvalid, s_bready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;

  axi_ram_arb2 #(.AWID(AW), .IDWID(IW), .DWID(DW), .WSTRB(SW), .WDEPTH(WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arid(arid[0]), .m0_araddr(araddr[0]), .m0_arlen(arlen[0]), .m0_arsize(arsize[0]),
    .m0_arburst(arburst[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
    .m0_rid(rid[0]), .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rlast(rlast[0]),
    .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
    .m0_awid(awid[0]), .m0_awaddr(awaddr[0]), .m0_awlen(awlen[0]), .m0_awsize(awsize[0]),
    .m0_awburst(awburst[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wlast(wlast[0]), .m0_wvalid(wvalid[0]),
    .m0_wready(wready[0]), .m0_bid(bid[0]), .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]),
    .m0_bready(bready[0]),
    .m1_arid(arid[1]), .m1_araddr(araddr[1]), .m1_arlen(arlen[1]), .m1_arsize(arsize[1]),
    .m1_arburst(arburst[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
    .m1_rid(rid[1]), .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rlast(rlast[1]),
    .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
    .m1_awid(awid[1]), .m1_awaddr(awaddr[1]), .m1_awlen(awlen[1]), .m1_awsize(awsize[1]),
    .m1_awburst(awburst[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wlast(wlast[1]), .m1_wvalid(wvalid[1]),
    .m1_wready(wready[1]), .m1_bid(bid[1]), .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]),
    .m1_bready(bready[1]),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      arvalid[i] = 1'b0; awvalid[i] = 1'b0; wvalid[i] = 1'b0; wlast[i] = 1'b0;
      rready[i] = 1'b0; bready[i] = 1'b0;
      arid[i] = IW'(10 + i); araddr[i] = AW'(32'h100 * (i + 1)); arlen[i] = 8'd0;
      arsize[i] = 3'd3; arburst[i] = BURST_INCR;
      awid[i] = IW'(10 + i); awaddr[i] = AW'(32'h400 * (i + 1)); awlen[i] = 8'd0;
      awsize[i] = 3'd3; awburst[i] = BURST_INCR;
      wdata[i] = '0; wstrb[i] = '1;
    end
    s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = RESP_OKAY; s_rlast = 1'b0;
    s_bvalid = 1'b0; s_bid = '0; s_bresp = RESP_OKAY;
  endtask

  // Drive every request/response valid and ready so a quiet output really means reset gating
  task automatic drive_busy();
    arvalid[0] = 1'b1; arvalid[1] = 1'b1; awvalid[1] = 1'b1; wvalid[0] = 1'b1;
    rready[0] = 1'b1; rready[1] = 1'b1; bready[0] = 1'b1; bready[1] = 1'b1;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    s_rvalid = 1'b1; s_rid = 5'h05; s_bvalid = 1'b1; s_bid = 5'h12;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_s_valids"}, {s_arvalid, s_awvalid, s_wvalid}, 3'b000);
    chk({tag, "_readys"}, {arready[0], arready[1], awready[0], awready[1],
                           wready[0], wready[1], s_rready, s_bready}, 8'h00);
    chk({tag, "_m_valids"}, {rvalid[0], rvalid[1], bvalid[0], bvalid[1]}, 4'h0);
  endtask

  typedef struct {
    logic       v0, v1, rdy;
    logic       ev;
    logic [4:0] eid;
    logic [1:0] erdy;
  } ar_vec_t;
  ar_vec_t tbl [10];

  // Round-robin owner of a channel: the held master, else first requester from pref
  function automatic int owner(input int lock, input int pref, input logic v0, input logic v1);
    logic v [2];
    v[0] = v0;
    v[1] = v1;
    if (lock >= 0) return lock;
    for (int k = 0; k < 2; k++) if (v[(pref + k) % 2]) return (pref + k) % 2;
    return -1;
  endfunction

  int   ar_pref, aw_pref, ar_lock, aw_lock, ag, wg, ws;
  int   wq [$];
  logic aev, wev, ewv, rs, bs;
  logic ar_hold [2], aw_hold [2];

  initial begin
    // ---------------- reset state ----------------
    rst_n = 1'b0;
    idle();
    drive_busy();
    @(negedge clk);
    chk_quiet("reset");
    tick();
    idle();
    rst_n = 1'b1;

    // ---------------- AR arbitration table ----------------
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h0A, 2'b01};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h1B, 2'b10};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h0A, 2'b01};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h1B, 2'b10};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h1B, 2'b00};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h1B, 2'b00};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h1B, 2'b00};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h1B, 2'b10};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'h0A, 2'b01};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 2'b00};
    for (int i = 0; i < 10; i++) begin
      tick();
      arvalid[0] = tbl[i].v0;
      arvalid[1] = tbl[i].v1;
      s_arready  = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("ar_valid[%0d]", i), s_arvalid, tbl[i].ev);
      chk($sformatf("ar_ready[%0d]", i), {arready[1], arready[0]}, tbl[i].erdy);
      if (tbl[i].ev) begin
        chk($sformatf("ar_id[%0d]", i), s_arid, tbl[i].eid);
        chk($sformatf("ar_addr[%0d]", i), s_araddr, tbl[i].eid[4] ? 32'h200 : 32'h100);
      end
    end

    // ---------------- W ordering: m0 len=3 then m1 len=1 ----------------
    tick();
    idle();
    s_awready = 1'b1; s_wready = 1'b1;
    awvalid[0] = 1'b1; awlen[0] = 8'd3;
    @(negedge clk);
    chk("wo_aw0_id", s_awid, 5'h0A);
    chk("wo_aw0_rdy", {awready[1], awready[0]}, 2'b01);
    tick();
    awvalid[0] = 1'b0;
    awvalid[1] = 1'b1; awlen[1] = 8'd1;
    wvalid[1] = 1'b1; wdata[1] = 64'hB0; wlast[1] = 1'b0;
    @(negedge clk);
    chk("wo_aw1_id", s_awid, 5'h1B);
    chk("wo_aw1_len", s_awlen, 8'd1);
    chk("wo_m1_early_wready", wready[1], 1'b0);
    tick();
    awvalid[1] = 1'b0;
    @(negedge clk);
    chk("wo_m1_blocked", {s_wvalid, wready[1]}, 2'b00);
    for (int b = 0; b < 4; b++) begin
      tick();
      wvalid[0] = 1'b1; wdata[0] = 64'hA0 + 64'(b); wlast[0] = (b == 3);
      @(negedge clk);
      chk($sformatf("wo_m0_beat%0d_data", b), s_wdata, 64'hA0 + 64'(b));
      chk($sformatf("wo_m0_beat%0d_rdy", b), {wready[1], wready[0], s_wlast}, {2'b01, (b == 3)});
    end
    for (int b = 0; b < 2; b++) begin
      tick();
      wvalid[0] = 1'b0;
      wdata[1] = 64'hB0 + 64'(b); wlast[1] = (b == 1);
      @(negedge clk);
      chk($sformatf("wo_m1_beat%0d_data", b), s_wdata, 64'hB0 + 64'(b));
      chk($sformatf("wo_m1_beat%0d_rdy", b), {wready[1], wready[0], s_wvalid}, 3'b101);
    end
    tick();
    @(negedge clk);
    chk("wo_empty", {s_wvalid, wready[1]}, 2'b00);

    // ---------------- W-order FIFO full ----------------
    tick();
    idle();
    s_awready = 1'b1;
    awvalid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("full_aw%0d", k), {s_awvalid, awready[0]}, (k < 4) ? 2'b11 : 2'b00);
      tick();
    end
    wvalid[0] = 1'b1; wlast[0] = 1'b1; s_wready = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle", {s_awvalid, awready[0], wready[0]}, 3'b001);
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("full_pushpop%0d", k), {awready[0], wready[0]}, 2'b11);
    end
    tick();
    awvalid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("full_drain%0d", k), wready[0], 1'b1);
      tick();
    end
    @(negedge clk);
    chk("full_drained", {s_wvalid, wready[0]}, 2'b00);

    // ---------------- response routing ----------------
    tick();
    idle();
    s_rvalid = 1'b1; s_rid = 5'h13; s_rlast = 1'b1; s_rdata = 64'h1234_5678_9ABC_DEF0;
    s_rresp = RESP_SLVERR; rready[0] = 1'b1; rready[1] = 1'b0;
    @(negedge clk);
    chk("r_valid_m1", {rvalid[1], rvalid[0]}, 2'b10);
    chk("r_id_m1", rid[1], 4'h3);
    chk("r_data_m1", rdata[1], 64'h1234_5678_9ABC_DEF0);
    chk("r_last_resp_m1", {rlast[1], rresp[1]}, 3'b110);
    chk("r_ready_held", s_rready, 1'b0);
    tick();
    rready[1] = 1'b1; rready[0] = 1'b0;
    s_bvalid = 1'b1; s_bid = 5'h02; bready[0] = 1'b1;
    @(negedge clk);
    chk("r_ready_pass", s_rready, 1'b1);
    chk("b_valid_m0", {bvalid[1], bvalid[0]}, 2'b01);
    chk("b_id_m0", bid[0], 4'h2);
    chk("b_ready", s_bready, 1'b1);

    // ---------------- reset mid-burst ----------------
    tick();
    idle();
    s_awready = 1'b1; awvalid[0] = 1'b1; awlen[0] = 8'd3;
    s_arready = 1'b1; arvalid[0] = 1'b1;
    @(negedge clk);
    chk("mr_ar_m0", {s_arid[4], arready[0]}, 2'b01);
    for (int b = 0; b < 3; b++) begin
      tick();
      idle();
      wvalid[0] = 1'b1; s_wready = 1'b1; wlast[0] = 1'b0;
      @(negedge clk);
      chk($sformatf("mr_beat%0d", b), wready[0], 1'b1);
    end
    drive_busy();
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    arvalid[0] = 1'b1; arvalid[1] = 1'b1; s_arready = 1'b1;
    wvalid[0] = 1'b1; s_wready = 1'b1;
    @(negedge clk);
    chk("mr_first_grant", {s_arid[4], arready[1], arready[0]}, 3'b001);
    chk("mr_fifo_empty", {s_wvalid, wready[0]}, 2'b00);

    // ---------------- randomized run against reference model ----------------
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ar_pref = 0; aw_pref = 0; ar_lock = -1; aw_lock = -1;
    wq.delete();
    for (int i = 0; i < 2; i++) begin
      ar_hold[i] = 1'b0;
      aw_hold[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!ar_hold[i]) begin
          arvalid[i] = ($urandom_range(0, 2) != 0);
          arid[i] = IW'($urandom); araddr[i] = $urandom; arlen[i] = 8'($urandom);
        end
        if (!aw_hold[i]) begin
          awvalid[i] = ($urandom_range(0, 2) == 0);
          awid[i] = IW'($urandom); awaddr[i] = $urandom; awlen[i] = 8'($urandom);
        end
        wvalid[i] = 1'($urandom_range(0, 1));
        wdata[i]  = {$urandom, $urandom};
        wlast[i]  = ($urandom_range(0, 2) == 0);
        rready[i] = 1'($urandom_range(0, 1));
        bready[i] = 1'($urandom_range(0, 1));
      end
      s_arready = 1'($urandom_range(0, 1));
      s_awready = 1'($urandom_range(0, 1));
      s_wready  = ($urandom_range(0, 3) != 0);
      s_rvalid  = 1'($urandom_range(0, 1));
      s_rid     = 5'($urandom);
      s_rdata   = {$urandom, $urandom};
      s_rlast   = 1'($urandom_range(0, 1));
      s_bvalid  = 1'($urandom_range(0, 1));
      s_bid     = 5'($urandom);
      @(negedge clk);

      ag  = owner(ar_lock, ar_pref, arvalid[0], arvalid[1]);
      aev = (ag >= 0) && arvalid[ag];
      chk("rnd_ar_valid", s_arvalid, aev);
      chk("rnd_ar_ready", {arready[1], arready[0]},
          (aev && s_arready) ? ((ag == 1) ? 2'b10 : 2'b01) : 2'b00);
      if (aev) chk("rnd_ar_fields", {s_arid, s_araddr, s_arlen}, {1'(ag), arid[ag], araddr[ag], arlen[ag]});

      wg  = owner(aw_lock, aw_pref, awvalid[0], awvalid[1]);
      wev = (wq.size() < WD) && (wg >= 0) && awvalid[wg];
      chk("rnd_aw_valid", s_awvalid, wev);
      chk("rnd_aw_ready", {awready[1], awready[0]},
          (wev && s_awready) ? ((wg == 1) ? 2'b10 : 2'b01) : 2'b00);
      if (wev) chk("rnd_aw_fields", {s_awid, s_awaddr, s_awlen}, {1'(wg), awid[wg], awaddr[wg], awlen[wg]});

      ws  = (wq.size() > 0) ? wq[0] : 0;
      ewv = (wq.size() > 0) && wvalid[ws];
      chk("rnd_w_valid", s_wvalid, ewv);
      chk("rnd_w_ready", {wready[1], wready[0]},
          ((wq.size() > 0) && s_wready) ? ((ws == 1) ? 2'b10 : 2'b01) : 2'b00);
      if (ewv) chk("rnd_w_data", {s_wdata[62:0], s_wlast}, {wdata[ws][62:0], wlast[ws]});

      rs = s_rid[IW];
      chk("rnd_r_valid", {rvalid[1], rvalid[0]}, s_rvalid ? (rs ? 2'b10 : 2'b01) : 2'b00);
      chk("rnd_r_ready", s_rready, rready[rs]);
      if (s_rvalid) chk("rnd_r_data", {rid[rs], rdata[rs][59:0]}, {s_rid[IW-1:0], s_rdata[59:0]});

      bs = s_bid[IW];
      chk("rnd_b_valid", {bvalid[1], bvalid[0]}, s_bvalid ? (bs ? 2'b10 : 2'b01) : 2'b00);
      chk("rnd_b_ready", s_bready, bready[bs]);
      if (s_bvalid) chk("rnd_b_id", bid[bs], s_bid[IW-1:0]);

      if (ewv && s_wready && wlast[ws]) wq.delete(0);
      if (aev && s_arready) begin
        ar_pref = 1 - ag; ar_lock = -1;
      end else if (aev) begin
        ar_lock = ag;
      end
      if (wev && s_awready) begin
        aw_pref = 1 - wg; aw_lock = -1;
        wq.push_back(wg);
      end else if (wev) begin
        aw_lock = wg;
      end
      for (int i = 0; i < 2; i++) begin
        ar_hold[i] = arvalid[i] && !(aev && s_arready && (ag == i));
        aw_hold[i] = awvalid[i] && !(wev && s_awready && (wg == i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
